// File: rtl/snn_window_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | snn_window_sequencer: runs one SNN classification window, then an argmax  |
// | scan over the readout accumulators.          Revision: 1.0               |
// +--------------------------------------------------------------------------+
module snn_window_sequencer #(
  parameter int NUM_CLASSES = 5,
  parameter int WIDTH_P     = 8,
  parameter int NUM_STEPS   = 16,
  parameter int PIPE_LAT    = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_i,
  input  logic [WIDTH_P-1:0]             sample_i,
  output logic [WIDTH_P-1:0]             data_o,
  output logic                           step_en_o,
  output logic                           clear_o,
  input  logic [NUM_CLASSES*WIDTH_P-1:0] acc_i,
  output logic                           busy_o,
  output logic                           result_valid_o,
  input  logic                           result_ready_i,
  output logic [7:0]                     class_o,
  output logic [WIDTH_P-1:0]             score_o
);

  localparam int STEP_W  = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int IDX_W   = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(NUM_STEPS - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_CLASSES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_SCAN  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [STEP_W-1:0]    step_cnt_q, step_cnt_d;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic [IDX_W-1:0]     scan_idx_q, scan_idx_d;
  logic [WIDTH_P-1:0]   sample_q, sample_d;
  logic [WIDTH_P-1:0]   best_q, best_d;
  logic [7:0]           best_idx_q, best_idx_d;
  logic [7:0]           class_q, class_d;
  logic [WIDTH_P-1:0]   score_q, score_d;

  logic [WIDTH_P-1:0]   acc_arr [NUM_CLASSES];
  logic [WIDTH_P-1:0]   acc_cur;

  generate
    for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_acc_unpack
      assign acc_arr[c] = acc_i[c*WIDTH_P +: WIDTH_P];
    end
  endgenerate

  assign acc_cur = acc_arr[scan_idx_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      step_cnt_q  <= '0;
      drain_cnt_q <= '0;
      scan_idx_q  <= '0;
      sample_q    <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      class_q     <= '0;
      score_q     <= '0;
    end else begin
      state_q     <= state_d;
      step_cnt_q  <= step_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      scan_idx_q  <= scan_idx_d;
      sample_q    <= sample_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      class_q     <= class_d;
      score_q     <= score_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    step_cnt_d  = step_cnt_q;
    drain_cnt_d = drain_cnt_q;
    scan_idx_d  = scan_idx_q;
    sample_d    = sample_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    class_d     = class_q;
    score_d     = score_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          sample_d = sample_i;
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        step_cnt_d = '0;
        state_d    = S_RUN;
      end
      S_RUN: begin
        if (step_cnt_q == STEP_LAST) begin
          drain_cnt_d = '0;
          scan_idx_d  = '0;
          best_d      = '0;
          best_idx_d  = '0;
          state_d     = (PIPE_LAT == 0) ? S_SCAN : S_DRAIN;
        end else begin
          step_cnt_d = step_cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = S_SCAN;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      S_SCAN: begin
        // Strict compare keeps the lowest index on ties.
        if (acc_cur > best_q) begin
          best_d     = acc_cur;
          best_idx_d = 8'(scan_idx_q);
        end
        if (scan_idx_q == IDX_LAST) begin
          class_d = best_idx_d;
          score_d = best_d;
          state_d = S_DONE;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (result_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign clear_o        = (state_q == S_CLEAR);
  assign step_en_o      = (state_q == S_RUN);
  assign data_o         = (state_q == S_RUN) ? sample_q : '0;
  assign busy_o         = (state_q != S_IDLE);
  assign result_valid_o = (state_q == S_DONE);
  assign class_o        = class_q;
  assign score_o        = score_q;

endmodule
`default_nettype wire

// File: tb/tb_snn_window_sequencer.sv
`default_nettype none
// Bench for snn_window_sequencer: scoreboarded argmax results plus
// cycle-exact checks of the window timing and control outputs.
module tb_snn_window_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [7:0]  sample_i;
  logic [7:0]  data_o;
  logic        step_en_o;
  logic        clear_o;
  logic [39:0] acc_i;
  logic        busy_o;
  logic        result_valid_o;
  logic        result_ready_i;
  logic [7:0]  class_o;
  logic [7:0]  score_o;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] cls;
    logic [7:0] score;
  } res_t;

  res_t exp_q[$];

  snn_window_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .sample_i       (sample_i),
    .data_o         (data_o),
    .step_en_o      (step_en_o),
    .clear_o        (clear_o),
    .acc_i          (acc_i),
    .busy_o         (busy_o),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .class_o        (class_o),
    .score_o        (score_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input logic [39:0] a);
    res_t r;
    logic [7:0] v;
    r.cls   = 8'd0;
    r.score = 8'd0;
    for (int c = 0; c < 5; c++) begin
      v = a[c*8 +: 8];
      if (v > r.score) begin
        r.score = v;
        r.cls   = 8'(c);
      end
    end
    return r;
  endfunction

  function automatic res_t next_exp();
    res_t r;
    r = '0;
    if (exp_q.size() > 0) r = exp_q.pop_front();
    return r;
  endfunction

  // Returns at the negedge of cycle k+1 (start accepted in cycle k).
  task automatic do_start(input logic [7:0] s, input logic [39:0] a);
    @(negedge clk);
    sample_i = s;
    acc_i    = a;
    start_i  = 1'b1;
    exp_q.push_back(model(a));
    @(negedge clk);
    start_i  = 1'b0;
    sample_i = ~s;
  endtask

  task automatic wait_valid(input int t0, output int t);
    t = t0;
    while (result_valid_o !== 1'b1 && t < 80) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_i = 1'b0;
    result_ready_i = 1'b0;
    sample_i = 8'h00;
    acc_i = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_o, result_valid_o, step_en_o, clear_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000", {busy_o, result_valid_o, step_en_o, clear_o});
    end
    checks++;
    if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 0", data_o); end
    checks++;
    if ({class_o, score_o} !== 16'h0000) begin
      errors++; $display("FAIL reset_result: got %0h expected 0", {class_o, score_o});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_argmax_timing();
    res_t e;
    logic [7:0] exp_data;
    do_start(8'h40, {8'd7, 8'd200, 8'd50, 8'd200, 8'd10});
    for (int t = 1; t <= 27; t++) begin
      if (t > 1) @(negedge clk);
      exp_data = (t >= 2 && t <= 17) ? 8'h40 : 8'h00;
      checks++;
      if (clear_o !== 1'(t == 1)) begin errors++; $display("FAIL clear t=%0d: got %b expected %b", t, clear_o, (t == 1)); end
      checks++;
      if (step_en_o !== 1'(t >= 2 && t <= 17)) begin errors++; $display("FAIL step_en t=%0d: got %b", t, step_en_o); end
      checks++;
      if (data_o !== exp_data) begin errors++; $display("FAIL data t=%0d: got %0h expected %0h", t, data_o, exp_data); end
      checks++;
      if (result_valid_o !== 1'(t == 27)) begin errors++; $display("FAIL valid t=%0d: got %b", t, result_valid_o); end
      checks++;
      if (busy_o !== 1'b1) begin errors++; $display("FAIL busy t=%0d: got %b expected 1", t, busy_o); end
    end
    e = next_exp();
    checks++;
    if (class_o !== e.cls) begin errors++; $display("FAIL argmax_class: got %0d expected %0d", class_o, e.cls); end
    checks++;
    if (score_o !== e.score) begin errors++; $display("FAIL argmax_score: got %0d expected %0d", score_o, e.score); end
    result_ready_i = 1'b1;
    @(negedge clk);
    result_ready_i = 1'b0;
    checks++;
    if ({result_valid_o, busy_o} !== 2'b00) begin
      errors++; $display("FAIL argmax_release: valid/busy got %b expected 00", {result_valid_o, busy_o});
    end
  endtask

  task automatic test_all_zero();
    res_t e;
    int t;
    do_start(8'h12, 40'd0);
    wait_valid(1, t);
    checks++;
    if (t !== 27) begin errors++; $display("FAIL zero_latency: got %0d expected 27", t); end
    e = next_exp();
    checks++;
    if ({class_o, score_o} !== {e.cls, e.score}) begin
      errors++; $display("FAIL zero_result: got %0d/%0d expected %0d/%0d", class_o, score_o, e.cls, e.score);
    end
    result_ready_i = 1'b1;
    @(negedge clk);
    result_ready_i = 1'b0;
  endtask

  task automatic test_backpressure();
    res_t e;
    int t;
    logic [7:0] c0, s0;
    do_start(8'h77, {8'd2, 8'd1, 8'd9, 8'd9, 8'd3});
    wait_valid(1, t);
    checks++;
    if (t !== 27) begin errors++; $display("FAIL bp_latency: got %0d expected 27", t); end
    c0 = class_o;
    s0 = score_o;
    e = next_exp();
    checks++;
    if ({c0, s0} !== {e.cls, e.score}) begin
      errors++; $display("FAIL bp_result: got %0d/%0d expected %0d/%0d", c0, s0, e.cls, e.score);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({result_valid_o, class_o, score_o} !== {1'b1, e.cls, e.score}) begin
        errors++; $display("FAIL bp_hold i=%0d: got %b/%0d/%0d", i, result_valid_o, class_o, score_o);
      end
    end
    result_ready_i = 1'b1;
    @(negedge clk);
    result_ready_i = 1'b0;
    checks++;
    if ({result_valid_o, busy_o} !== 2'b00) begin
      errors++; $display("FAIL bp_release: valid/busy got %b expected 00", {result_valid_o, busy_o});
    end
    checks++;
    if ({class_o, score_o} !== {e.cls, e.score}) begin
      errors++; $display("FAIL bp_keep: got %0d/%0d after transfer", class_o, score_o);
    end
  endtask

  task automatic test_start_ignored();
    res_t e;
    int t, nclr, nstep, nbad;
    logic [39:0] a;
    a = {8'd40, 8'd90, 8'd11, 8'd90, 8'd91};
    @(negedge clk);
    sample_i = 8'h33;
    acc_i    = a;
    start_i  = 1'b1;
    exp_q.push_back(model(a));
    @(negedge clk);
    t = 1; nclr = 0; nstep = 0; nbad = 0;
    while (result_valid_o !== 1'b1 && t < 80) begin
      if (clear_o) nclr++;
      if (step_en_o) nstep++;
      if (step_en_o && data_o !== 8'h33) nbad++;
      sample_i = 8'($urandom);
      @(negedge clk);
      t++;
    end
    start_i = 1'b0;
    checks++;
    if (t !== 27) begin errors++; $display("FAIL ign_latency: got %0d expected 27", t); end
    checks++;
    if (nclr !== 1) begin errors++; $display("FAIL ign_clears: got %0d expected 1", nclr); end
    checks++;
    if (nstep !== 16) begin errors++; $display("FAIL ign_steps: got %0d expected 16", nstep); end
    checks++;
    if (nbad !== 0) begin errors++; $display("FAIL ign_data: got %0d bad cycles expected 0", nbad); end
    e = next_exp();
    checks++;
    if ({class_o, score_o} !== {e.cls, e.score}) begin
      errors++; $display("FAIL ign_result: got %0d/%0d expected %0d/%0d", class_o, score_o, e.cls, e.score);
    end
    result_ready_i = 1'b1;
    @(negedge clk);
    result_ready_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL ign_idle: busy got %b expected 0", busy_o); end
    a = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    do_start(8'h5A, a);
    @(negedge clk);
    checks++;
    if ({step_en_o, data_o} !== {1'b1, 8'h5A}) begin
      errors++; $display("FAIL second_data: got %b/%0h expected 1/5a", step_en_o, data_o);
    end
    wait_valid(2, t);
    checks++;
    if (t !== 27) begin errors++; $display("FAIL second_latency: got %0d expected 27", t); end
    e = next_exp();
    checks++;
    if ({class_o, score_o} !== {e.cls, e.score}) begin
      errors++; $display("FAIL second_result: got %0d/%0d expected %0d/%0d", class_o, score_o, e.cls, e.score);
    end
    result_ready_i = 1'b1;
    @(negedge clk);
    result_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    res_t e;
    int t, nvalid;
    do_start(8'h21, {8'd100, 8'd1, 8'd1, 8'd1, 8'd1});
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    checks++;
    if ({busy_o, result_valid_o, step_en_o, clear_o, data_o} !== 12'h000) begin
      errors++; $display("FAIL midrst_outputs: got %0h expected 0", {busy_o, result_valid_o, step_en_o, clear_o, data_o});
    end
    checks++;
    if ({class_o, score_o} !== 16'h0000) begin
      errors++; $display("FAIL midrst_result: got %0h expected 0", {class_o, score_o});
    end
    nvalid = 0;
    repeat (40) begin
      @(negedge clk);
      if (result_valid_o) nvalid++;
    end
    checks++;
    if (nvalid !== 0) begin errors++; $display("FAIL midrst_novalid: got %0d valid cycles expected 0", nvalid); end
    do_start(8'h0F, {8'd3, 8'd250, 8'd4, 8'd5, 8'd6});
    wait_valid(1, t);
    checks++;
    if (t !== 27) begin errors++; $display("FAIL midrst_latency: got %0d expected 27", t); end
    e = next_exp();
    checks++;
    if ({class_o, score_o} !== {e.cls, e.score}) begin
      errors++; $display("FAIL midrst_result2: got %0d/%0d expected %0d/%0d", class_o, score_o, e.cls, e.score);
    end
    result_ready_i = 1'b1;
    @(negedge clk);
    result_ready_i = 1'b0;
  endtask

  task automatic test_random();
    res_t e;
    int t;
    logic [39:0] a;
    for (int n = 0; n < 6; n++) begin
      for (int c = 0; c < 5; c++) a[c*8 +: 8] = 8'($urandom_range(0, 4) * 60);
      do_start(8'($urandom), a);
      wait_valid(1, t);
      checks++;
      if (t !== 27) begin errors++; $display("FAIL rand%0d_latency: got %0d expected 27", n, t); end
      e = next_exp();
      checks++;
      if ({class_o, score_o} !== {e.cls, e.score}) begin
        errors++; $display("FAIL rand%0d_result: acc=%0h got %0d/%0d expected %0d/%0d", n, a, class_o, score_o, e.cls, e.score);
      end
      result_ready_i = 1'b1;
      @(negedge clk);
      result_ready_i = 1'b0;
      checks++;
      if (result_valid_o !== 1'b0) begin errors++; $display("FAIL rand%0d_release: valid got %b", n, result_valid_o); end
    end
  endtask

  initial begin
    test_reset();
    test_argmax_timing();
    test_all_zero();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
